mem_dmem_ctrl: RTL and testbench

- MEM-stage data-memory controller and the producer side of the MEM/WB pipeline register.
- Takes the EX/MEM-stage access request and runs a req/ready handshake with the data memory, which may take several cycles.
- Sign/zero-extends load data and builds the final write-back value. Both results feed MEM/WB.
- Stalls the pipeline while an access is outstanding.

---
 rtl/mem_dmem_ctrl_pkg.sv | 30 +++
 rtl/mem_dmem_ctrl_load_ext.sv | 26 ++
 rtl/mem_dmem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_dmem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dmem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory controller: access sizes,
// write-back select codes and the access FSM states.
package mem_dmem_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_DRAM = 2'b01;
    localparam logic [1:0] WD_PC4  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // funct3[1:0] carries the size; anything wider than a halfword is word-checked.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_dmem_ctrl_load_ext.sv
// Byte/halfword lane select and sign/zero extension of a read word.
module mem_load_ext
    import mem_dmem_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_dmem_ctrl.sv
// MEM-stage data-memory controller: req/ready handshake with timeout, store lane
// steering, load extraction and write-back select feeding MEM/WB.
module mem_dmem_ctrl
    import mem_dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_have_inst,
    input  logic [31:0] MEM_ALUC,
    input  logic [31:0] MEM_rD2,
    input  logic        MEM_dram_re,
    input  logic        MEM_dram_we,
    input  logic [2:0]  MEM_funct3,
    input  logic [1:0]  MEM_wd_sel,
    input  logic [31:0] MEM_pc4,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic [3:0]  dram_wstrb,
    input  logic        dram_ready,
    input  logic [31:0] dram_rdata,
    output logic [31:0] MEM_DRAMrd,
    output logic [31:0] MEM_wD,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam int             CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;
    logic          r_err, r_req, r_we;
    logic [31:0]   r_addr, r_wdata;
    logic [3:0]    r_wstrb;

    logic        w_acc, w_mis, w_go, w_store, w_load, w_stall;
    logic [31:0] w_wdata, w_ext;
    logic [3:0]  w_wstrb;

    assign w_acc   = mem_have_inst & (MEM_dram_re | MEM_dram_we);
    assign w_mis   = misaligned(MEM_funct3, MEM_ALUC[1:0]);
    assign w_go    = w_acc & ~w_mis;
    assign w_store = MEM_dram_we;
    assign w_load  = mem_have_inst & MEM_dram_re & ~MEM_dram_we;

    always_comb begin
        w_wdata = MEM_rD2;
        w_wstrb = 4'b1111;
        case (MEM_funct3[1:0])
            2'b00: begin
                w_wdata = {4{MEM_rD2[7:0]}};
                w_wstrb = 4'b0001 << MEM_ALUC[1:0];
            end
            2'b01: begin
                w_wdata = {2{MEM_rD2[15:0]}};
                w_wstrb = 4'b0011 << {MEM_ALUC[1], 1'b0};
            end
            default: ;
        endcase
        if (!w_store) begin
            w_wdata = '0;
            w_wstrb = '0;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_go;
                if (w_go) w_next = S_REQ;
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (dram_ready || r_cnt == CNT_LAST) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_go) begin
                        r_req   <= 1'b1;
                        r_we    <= w_store;
                        r_addr  <= {MEM_ALUC[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_wstrb <= w_wstrb;
                    end else if (w_acc) begin
                        r_err <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (dram_ready) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_wstrb <= '0;
                        r_rdata <= dram_rdata;
                    end else if (r_cnt == CNT_LAST) begin
                        // Abort: no data ever arrives, so the load reads as zero.
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_wstrb <= '0;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_load_ext u_ext (
        .i_rdata  (r_rdata),
        .i_off    (MEM_ALUC[1:0]),
        .i_funct3 (MEM_funct3),
        .o_data   (w_ext)
    );

    assign MEM_DRAMrd = (w_load & ~w_mis) ? w_ext : '0;

    always_comb begin
        case (MEM_wd_sel)
            WD_DRAM: MEM_wD = MEM_DRAMrd;
            WD_PC4:  MEM_wD = MEM_pc4;
            default: MEM_wD = MEM_ALUC;
        endcase
    end

    // Reset gates the stall so a request dropped mid-flight cannot freeze the pipe.
    assign mem_stall  = w_stall & rst_n;
    assign dram_req   = r_req;
    assign dram_we    = r_we;
    assign dram_addr  = r_addr;
    assign dram_wdata = r_wdata;
    assign dram_wstrb = r_wstrb;
    assign mem_err    = r_err;

endmodule

// File: tb/tb_mem_dmem_ctrl.sv
// Bench for mem_dmem_ctrl: directed vector table, reset-mid-access sequence and
// randomized accesses against a behavioural model.
module tb_mem_dmem_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_have_inst;
    logic [31:0] MEM_ALUC, MEM_rD2, MEM_pc4;
    logic        MEM_dram_re, MEM_dram_we;
    logic [2:0]  MEM_funct3;
    logic [1:0]  MEM_wd_sel;
    logic        dram_req, dram_we;
    logic [31:0] dram_addr, dram_wdata;
    logic [3:0]  dram_wstrb;
    logic        dram_ready;
    logic [31:0] dram_rdata;
    logic [31:0] MEM_DRAMrd, MEM_wD;
    logic        mem_stall, mem_err;

    always #5 clk = ~clk;

    mem_dmem_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_have_inst(mem_have_inst),
        .MEM_ALUC(MEM_ALUC), .MEM_rD2(MEM_rD2), .MEM_dram_re(MEM_dram_re),
        .MEM_dram_we(MEM_dram_we), .MEM_funct3(MEM_funct3), .MEM_wd_sel(MEM_wd_sel),
        .MEM_pc4(MEM_pc4), .dram_req(dram_req), .dram_we(dram_we),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_wstrb(dram_wstrb),
        .dram_ready(dram_ready), .dram_rdata(dram_rdata), .MEM_DRAMrd(MEM_DRAMrd),
        .MEM_wD(MEM_wD), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        re, we;
        logic [2:0]  f3;
        logic [31:0] addr, rd2, rdata;
        int          delay;     // ready on REQ cycle delay+1; -1 = never
        logic [1:0]  sel;
        logic [31:0] pc4;
        logic [31:0] e_rd, e_wd;
        int          e_stall;
        logic        e_err;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(input logic re, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rd2,
                                input logic [31:0] rdata, input int delay,
                                input logic [1:0] sel, input logic [31:0] pc4,
                                input logic [31:0] e_rd, input logic [31:0] e_wd,
                                input int e_stall, input logic e_err,
                                input logic [3:0] e_wstrb, input logic [31:0] e_wdata);
        vec_t v;
        v.re = re; v.we = we; v.f3 = f3; v.addr = addr; v.rd2 = rd2; v.rdata = rdata;
        v.delay = delay; v.sel = sel; v.pc4 = pc4; v.e_rd = e_rd; v.e_wd = e_wd;
        v.e_stall = e_stall; v.e_err = e_err; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Reference: expected results from the access rules, with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        int unsigned sz = v.f3[1:0];
        int unsigned off = v.addr[1:0];
        logic acc = v.re | v.we;
        logic mis = (sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0);
        logic [31:0] val = 32'd0;
        if (v.re && !v.we && !mis && v.delay >= 0) begin
            if (sz == 0) begin
                val = (v.rdata >> (8 * off)) & 32'hFF;
                if (!v.f3[2] && val >= 32'd128) val = val - 32'd256;
            end else if (sz == 1) begin
                val = (v.rdata >> (16 * (off / 2))) & 32'hFFFF;
                if (!v.f3[2] && val >= 32'd32768) val = val - 32'd65536;
            end else begin
                val = v.rdata;
            end
        end
        o.e_rd    = val;
        o.e_wd    = (v.sel == 2'b10) ? v.pc4 : (v.sel == 2'b01) ? val : v.addr;
        o.e_stall = (!acc || mis) ? 0 : (v.delay < 0 ? TO + 1 : v.delay + 2);
        o.e_err   = acc && (mis || v.delay < 0);
        o.e_wstrb = 4'b0000;
        o.e_wdata = v.rd2;
        if (v.we) begin
            if (sz == 0) begin
                o.e_wstrb = 4'(1 << off);
                o.e_wdata = v.rd2[7:0] * 32'h0101_0101;
            end else if (sz == 1) begin
                o.e_wstrb = 4'(3 << (2 * (off / 2)));
                o.e_wdata = v.rd2[15:0] * 32'h0001_0001;
            end else begin
                o.e_wstrb = 4'b1111;
            end
        end
        return o;
    endfunction

    task automatic drive(input vec_t v);
        mem_have_inst = 1'b1;
        MEM_dram_re = v.re;  MEM_dram_we = v.we;  MEM_funct3 = v.f3;
        MEM_ALUC = v.addr;   MEM_rD2 = v.rd2;     MEM_wd_sel = v.sel;
        MEM_pc4 = v.pc4;     dram_rdata = v.rdata; dram_ready = 1'b0;
    endtask

    task automatic idle_inputs();
        mem_have_inst = 1'b0; MEM_dram_re = 1'b0; MEM_dram_we = 1'b0;
        dram_ready = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int stalls = 0, nreq = 0, errs = 0;
        bit done = 0, moved = 0;
        logic [31:0] exp_addr = {v.addr[31:2], 2'b00};
        @(posedge clk); #1;
        drive(v);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (dram_req) begin
                nreq++;
                if (dram_addr !== exp_addr) moved = 1;
                if (nreq == 1) begin
                    chk({nm, ".we"}, 32'(dram_we), 32'(v.we));
                    chk({nm, ".wstrb"}, 32'(dram_wstrb), 32'(v.e_wstrb));
                    if (v.we) chk({nm, ".wdata"}, dram_wdata, v.e_wdata);
                end
                dram_ready = (v.delay >= 0 && nreq == v.delay + 1);
            end else begin
                dram_ready = 1'b0;
            end
            if (mem_err) errs++;
            if (mem_stall) stalls++;
            else begin
                done = 1;
                chk({nm, ".DRAMrd"}, MEM_DRAMrd, v.e_rd);
                chk({nm, ".wD"}, MEM_wD, v.e_wd);
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s.complete stall never released within 100 cycles", nm);
        end
        chk({nm, ".stalls"}, 32'(stalls), 32'(v.e_stall));
        chk({nm, ".reqcyc"}, 32'(nreq), 32'(v.e_stall > 0 ? v.e_stall - 1 : 0));
        if (nreq > 0) chk({nm, ".addr_stable"}, 32'(moved), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) begin
            @(negedge clk);
            if (mem_err) errs++;
        end
        chk({nm, ".err_pulses"}, 32'(errs), 32'(v.e_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[14];
    vec_t rv;
    int   f3s[5] = '{0, 1, 2, 4, 5};

    initial begin
        tbl[0]  = mk(1,0,3'b010,32'h10,  0,            32'hDEADBEEF,0, 2'b01,32'h4,  32'hDEADBEEF,32'hDEADBEEF,2,0,4'h0,0);
        tbl[1]  = mk(1,0,3'b000,32'h13,  0,            32'h80FF0000,0, 2'b00,32'h8,  32'hFFFFFF80,32'h13,      2,0,4'h0,0);
        tbl[2]  = mk(1,0,3'b100,32'h13,  0,            32'h80FF0000,0, 2'b01,32'h8,  32'h80,      32'h80,      2,0,4'h0,0);
        tbl[3]  = mk(1,0,3'b101,32'h12,  0,            32'h80FF0000,0, 2'b01,32'h8,  32'h80FF,    32'h80FF,    2,0,4'h0,0);
        tbl[4]  = mk(0,1,3'b001,32'h22,  32'h1234ABCD, 0,           4, 2'b00,32'h8,  0,           32'h22,      6,0,4'hC,32'hABCDABCD);
        tbl[5]  = mk(1,0,3'b010,32'h06,  0,            32'h55555555,0, 2'b01,32'h8,  0,           0,           0,1,4'h0,0);
        tbl[6]  = mk(1,0,3'b010,32'h40,  0,            32'h77777777,-1,2'b01,32'h8,  0,           0,           TO+1,1,4'h0,0);
        tbl[7]  = mk(0,0,3'b010,32'h77,  0,            0,           0, 2'b10,32'h104,0,           32'h104,     0,0,4'h0,0);
        tbl[8]  = mk(1,0,3'b001,32'h06,  0,            32'h80017F00,0, 2'b01,32'h8,  32'hFFFF8001,32'hFFFF8001,2,0,4'h0,0);
        tbl[9]  = mk(0,1,3'b000,32'h15,  32'h000000AB, 0,           1, 2'b00,32'h8,  0,           32'h15,      3,0,4'h2,32'hABABABAB);
        tbl[10] = mk(1,1,3'b010,32'h30,  32'hCAFEF00D, 32'h11111111,2, 2'b01,32'h8,  0,           0,           4,0,4'hF,32'hCAFEF00D);
        tbl[11] = mk(1,0,3'b001,32'h21,  0,            32'h11111111,0, 2'b00,32'h8,  0,           32'h21,      0,1,4'h0,0);
        tbl[12] = mk(1,0,3'b000,32'h11,  0,            32'h00007F00,0, 2'b01,32'h8,  32'h7F,      32'h7F,      2,0,4'h0,0);
        tbl[13] = mk(0,0,3'b000,32'h1234,0,            0,           0, 2'b11,32'h8,  0,           32'h1234,    0,0,4'h0,0);

        rst_n = 1'b0;
        MEM_ALUC = '0; MEM_rD2 = '0; MEM_pc4 = '0; MEM_funct3 = '0; MEM_wd_sel = '0;
        dram_rdata = '0;
        idle_inputs();
        #12;
        chk("rst.req",   32'(dram_req),   0);
        chk("rst.we",    32'(dram_we),    0);
        chk("rst.wstrb", 32'(dram_wstrb), 0);
        chk("rst.addr",  dram_addr,       0);
        chk("rst.wdata", dram_wdata,      0);
        chk("rst.stall", 32'(mem_stall),  0);
        chk("rst.err",   32'(mem_err),    0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while a load waits in REQ: request and stall must drop at once.
        begin
            bit seen = 0;
            @(posedge clk); #1;
            drive(mk(1,0,3'b010,32'h50,0,32'h12345678,-1,2'b01,32'h8,0,0,0,0,4'h0,0));
            for (int c = 0; c < 5 && !seen; c++) begin
                @(negedge clk);
                if (dram_req) seen = 1;
            end
            chk("rstmid.req_seen", 32'(seen), 1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("rstmid.req",   32'(dram_req),  0);
            chk("rstmid.stall", 32'(mem_stall), 0);
            @(negedge clk);
            rst_n = 1'b1;
            idle_inputs();
            run_op(tbl[7], "rstmid.pc4");
        end

        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 3);
            rv.re    = (k == 1 || k == 2);
            rv.we    = (k == 3);
            if (k == 2 && $urandom_range(0, 3) == 0) rv.we = 1'b1;
            rv.f3    = rv.we ? 3'($urandom_range(0, 2)) : 3'(f3s[$urandom_range(0, 4)]);
            rv.addr  = $urandom;
            rv.rd2   = $urandom;
            rv.rdata = $urandom;
            rv.delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            rv.sel   = 2'($urandom_range(0, 3));
            rv.pc4   = $urandom;
            rv = model(rv);
            run_op(rv, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
